train_center_cal_rx: RTL and testbench
======================================

# train_center_cal_rx

Responder side of the MBTRAIN data-to-clock center-calibration handshake; partner of the initiator FSM on the remote die. Answers the partner's start/end requests over the sideband and enables the local RX point-test engine between them. Captures the per-lane pass/fail result for the LTSM. Shares the sideband transmit mux with the local initiator.

## Interface
- TIMEOUT_CYCLES, 1024, wait-state timeout limit (used only with the macro)
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width
- clk  in  1  block clock
- rst  in  1  asynchronous, active-high reset
- i_en  in  1  substate enable from the MBTRAIN controller
- i_decoded_sideband_message  in  4  decoded incoming message: 0001 start_req, 0011 end_req
- i_sideband_valid  in  1  qualifies i_decoded_sideband_message
- i_busy_negedge_detected  in  1  sideband serializer finished a message
- i_valid_tx  in  1  local initiator's valid is pending
- i_rx_pt_done  in  1  one-cycle pulse, RX point test complete
- i_rx_lanes_result  in  16  per-lane pass(1)/fail(0), valid with i_rx_pt_done
- o_sideband_message  out  4  0010 start_resp, 0100 end_resp, else 0000
- o_valid_rx  out  1  request to send o_sideband_message
- o_rx_pt_en  out  1  enables RX point test / pattern compare
- o_lanes_result  out  16  captured lane result
- o_test_ack  out  1  handshake complete
- o_timeout  out  1  partner did not respond in time

## Operation
- Reset: state IDLE; every output 0.
- States: IDLE, WAIT_START_REQ, START_RESP, RX_TEST, END_RESP, TEST_FINISHED.
- IDLE -> WAIT_START_REQ when i_en=1.
- WAIT_START_REQ -> START_RESP on i_sideband_valid && message==0001. Other messages are ignored.
- START_RESP: single cycle. o_sideband_message=0010, o_valid_rx=1. Always -> RX_TEST.
- RX_TEST: o_rx_pt_en=1. o_lanes_result is cleared on entry. It loads i_rx_lanes_result on each i_rx_pt_done; the last pulse wins. -> END_RESP on i_sideband_valid && message==0011.
- end_req before any i_rx_pt_done: o_lanes_result stays 0000h (all lanes fail).
- i_rx_pt_done on the same cycle as end_req: the result is captured.
- END_RESP: single cycle. o_rx_pt_en=0, o_sideband_message=0100, o_valid_rx=1. Always -> TEST_FINISHED.
- TEST_FINISHED: o_test_ack=1 and o_sideband_message=0000. o_lanes_result is held. Stays here until i_en=0.
- i_en=0 in any state: next edge goes to IDLE and clears every output except o_lanes_result, which is held until the next RX_TEST entry.
- o_valid_rx is set on entry to START_RESP/END_RESP. It is cleared when i_busy_negedge_detected && !i_valid_tx, and on i_en=0. Set has priority over clear on the same edge.
- Reset asserted mid-operation: immediate return to the reset values.

## Timing
- All outputs are registered from next-state. No combinational input-to-output path.
- start_req sampled at edge N (cs=WAIT_START_REQ). At edge N+1: o_sideband_message=0010, o_valid_rx=1. At edge N+2: o_rx_pt_en=1.
- end_req sampled at edge M. At edge M+1: o_sideband_message=0100, o_valid_rx=1, o_rx_pt_en=0. At edge M+2: o_test_ack=1.
- i_rx_pt_done at edge K updates o_lanes_result at edge K+1.
- o_valid_rx stays high until the qualified busy negedge, independent of state.

## Configuration
- TRAIN_CENTER_CAL_RX_TIMEOUT_EN defined:
  - A CNT_W counter runs in WAIT_START_REQ and RX_TEST. It is cleared on every state change.
  - When the count reaches TIMEOUT_CYCLES: o_timeout=1 (sticky until i_en=0 or rst), o_rx_pt_en=0, and the FSM goes directly to TEST_FINISHED with o_test_ack=1 and no response sent.
- Macro not defined: no counter is built; o_timeout is tied to 0.

## Test plan
- Nominal handshake: rst, i_en=1, start_req, then pt_done with A5A5h, then end_req -> 0010/valid at N+1, pt_en at N+2, 0100/valid at M+1, o_test_ack=1, o_lanes_result=A5A5h.
- Valid arbitration: busy negedge with i_valid_tx=1 -> o_valid_rx stays 1. Busy negedge with i_valid_tx=0 -> o_valid_rx drops the next edge.
- end_req with no pt_done -> o_lanes_result=0000h, o_test_ack=1.
- Two pt_done pulses (FFFFh then 00F0h) -> o_lanes_result=00F0h. pt_done together with end_req -> captured value is reported.
- i_en=0 in RX_TEST, and rst pulsed in END_RESP -> IDLE, all outputs 0, no end_resp emitted. A subsequent i_en=1 restarts cleanly.
- With the macro and TIMEOUT_CYCLES=16: no start_req -> o_timeout=1 and o_test_ack=1 after 16 cycles in WAIT_START_REQ. Without the macro -> FSM waits indefinitely and o_timeout=0.

Source files
------------

// File: rtl/train_center_cal_rx_if.sv
// Sideband/handshake bundle between the MBTRAIN center-cal responder and its surroundings.
interface train_center_cal_rx_if;
  logic        i_en;
  logic [3:0]  i_decoded_sideband_message;
  logic        i_sideband_valid;
  logic        i_busy_negedge_detected;
  logic        i_valid_tx;
  logic        i_rx_pt_done;
  logic [15:0] i_rx_lanes_result;
  logic [3:0]  o_sideband_message;
  logic        o_valid_rx;
  logic        o_rx_pt_en;
  logic [15:0] o_lanes_result;
  logic        o_test_ack;
  logic        o_timeout;

  modport slave (
    input  i_en, i_decoded_sideband_message, i_sideband_valid,
           i_busy_negedge_detected, i_valid_tx, i_rx_pt_done, i_rx_lanes_result,
    output o_sideband_message, o_valid_rx, o_rx_pt_en, o_lanes_result,
           o_test_ack, o_timeout
  );

  modport master (
    output i_en, i_decoded_sideband_message, i_sideband_valid,
           i_busy_negedge_detected, i_valid_tx, i_rx_pt_done, i_rx_lanes_result,
    input  o_sideband_message, o_valid_rx, o_rx_pt_en, o_lanes_result,
           o_test_ack, o_timeout
  );
endinterface

// File: rtl/train_center_cal_rx.sv
// MBTRAIN data-to-clock center-calibration responder: answers start/end requests and
// captures the RX point-test lane result. Optional wait timeout: TRAIN_CENTER_CAL_RX_TIMEOUT_EN.
module train_center_cal_rx #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  train_center_cal_rx_if.slave  sb
);

  localparam logic [3:0] MSG_START_REQ  = 4'b0001;
  localparam logic [3:0] MSG_START_RESP = 4'b0010;
  localparam logic [3:0] MSG_END_REQ    = 4'b0011;
  localparam logic [3:0] MSG_END_RESP   = 4'b0100;

  if (TIMEOUT_CYCLES < 1 || (2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_param
    $error("train_center_cal_rx: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    IDLE, WAIT_START_REQ, START_RESP, RX_TEST, END_RESP, TEST_FINISHED
  } state_t;

  state_t state, next;
  logic   start_req, end_req, timeout_hit;

  assign start_req = sb.i_sideband_valid && (sb.i_decoded_sideband_message == MSG_START_REQ);
  assign end_req   = sb.i_sideband_valid && (sb.i_decoded_sideband_message == MSG_END_REQ);

`ifdef TRAIN_CENTER_CAL_RX_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;

  assign waiting     = (state == WAIT_START_REQ) || (state == RX_TEST);
  assign timeout_hit = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        wait_cnt <= '0;
    else if (waiting && next == state) wait_cnt <= wait_cnt + 1'b1;
    else                            wait_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              sb.o_timeout <= 1'b0;
    else if (!sb.i_en)    sb.o_timeout <= 1'b0;
    else if (timeout_hit) sb.o_timeout <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb.o_timeout <= 1'b0;
    else     sb.o_timeout <= 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // A real request wins over a timeout landing on the same cycle.
  always_comb begin
    next = state;
    if (!sb.i_en) begin
      next = IDLE;
    end else begin
      case (state)
        IDLE:           next = WAIT_START_REQ;
        WAIT_START_REQ: if (start_req)        next = START_RESP;
                        else if (timeout_hit) next = TEST_FINISHED;
        START_RESP:     next = RX_TEST;
        RX_TEST:        if (end_req)          next = END_RESP;
                        else if (timeout_hit) next = TEST_FINISHED;
        END_RESP:       next = TEST_FINISHED;
        TEST_FINISHED:  next = TEST_FINISHED;
        default:        next = IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state so no input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.o_sideband_message <= 4'b0000;
      sb.o_rx_pt_en         <= 1'b0;
      sb.o_test_ack         <= 1'b0;
    end else begin
      sb.o_sideband_message <= (next == START_RESP) ? MSG_START_RESP :
                               (next == END_RESP)   ? MSG_END_RESP   : 4'b0000;
      sb.o_rx_pt_en         <= (next == RX_TEST);
      sb.o_test_ack         <= (next == TEST_FINISHED);
    end
  end

  // Valid is raised on response entry and held until the serializer drains it,
  // unless the local initiator still has its own message pending on the shared mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sb.o_valid_rx <= 1'b0;
    else if (!sb.i_en)
      sb.o_valid_rx <= 1'b0;
    else if ((next == START_RESP || next == END_RESP) && next != state)
      sb.o_valid_rx <= 1'b1;
    else if (sb.i_busy_negedge_detected && !sb.i_valid_tx)
      sb.o_valid_rx <= 1'b0;
  end

  // Result defaults to all-fail on RX_TEST entry; the last done pulse wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sb.o_lanes_result <= 16'h0000;
    else if (state != RX_TEST && next == RX_TEST)
      sb.o_lanes_result <= 16'h0000;
    else if (state == RX_TEST && sb.i_en && sb.i_rx_pt_done)
      sb.o_lanes_result <= sb.i_rx_lanes_result;
  end

endmodule

// File: tb/tb_train_center_cal_rx.sv
// Directed bench for train_center_cal_rx (default build, or with TRAIN_CENTER_CAL_RX_TIMEOUT_EN).
module tb_train_center_cal_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  train_center_cal_rx_if sb_if ();

  train_center_cal_rx #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // msg, valid, pt_en, ack, timeout in one call
  task automatic chk_out(input string tag, input logic [3:0] msg, input logic vld,
                         input logic pten, input logic ack, input logic to);
    chk({tag, ".msg"},   {12'h0, sb_if.o_sideband_message}, {12'h0, msg});
    chk({tag, ".valid"}, {15'h0, sb_if.o_valid_rx},         {15'h0, vld});
    chk({tag, ".pt_en"}, {15'h0, sb_if.o_rx_pt_en},         {15'h0, pten});
    chk({tag, ".ack"},   {15'h0, sb_if.o_test_ack},         {15'h0, ack});
    chk({tag, ".tmo"},   {15'h0, sb_if.o_timeout},          {15'h0, to});
  endtask

  task automatic sbmsg(input logic v, input logic [3:0] m);
    sb_if.i_sideband_valid           = v;
    sb_if.i_decoded_sideband_message = m;
  endtask

  task automatic ptdone(input logic d, input logic [15:0] r);
    sb_if.i_rx_pt_done      = d;
    sb_if.i_rx_lanes_result = r;
  endtask

  initial begin
    sb_if.i_en = 1'b0;
    sb_if.i_busy_negedge_detected = 1'b0;
    sb_if.i_valid_tx = 1'b0;
    sbmsg(1'b0, 4'h0);
    ptdone(1'b0, 16'h0);
    step(); step();
    chk_out("reset", 4'h0, 0, 0, 0, 0);
    chk("reset.lanes", sb_if.o_lanes_result, 16'h0000);

    // Nominal handshake
    rst = 1'b0; sb_if.i_en = 1'b1;
    step();                                     // WAIT_START_REQ
    sbmsg(1'b1, 4'b0010); step();               // not a start_req
    chk_out("ignore", 4'h0, 0, 0, 0, 0);
    sbmsg(1'b1, 4'b0001); step();               // START_RESP
    chk_out("start_resp", 4'b0010, 1, 0, 0, 0);
    sbmsg(1'b0, 4'h0); step();                  // RX_TEST
    chk_out("rx_test", 4'h0, 1, 1, 0, 0);
    chk("rx_test.lanes", sb_if.o_lanes_result, 16'h0000);
    sb_if.i_busy_negedge_detected = 1'b1; sb_if.i_valid_tx = 1'b1; step();
    chk("arb_hold", {15'h0, sb_if.o_valid_rx}, 16'h1);
    sb_if.i_valid_tx = 1'b0; step();
    chk("arb_drop", {15'h0, sb_if.o_valid_rx}, 16'h0);
    sb_if.i_busy_negedge_detected = 1'b0;
    ptdone(1'b1, 16'hA5A5); step();
    chk("capture", sb_if.o_lanes_result, 16'hA5A5);
    ptdone(1'b0, 16'h0);
    sbmsg(1'b1, 4'b0011); step();               // END_RESP
    chk_out("end_resp", 4'b0100, 1, 0, 0, 0);
    sbmsg(1'b0, 4'h0); step();                  // TEST_FINISHED
    chk_out("finished", 4'h0, 1, 0, 1, 0);
    chk("finished.lanes", sb_if.o_lanes_result, 16'hA5A5);
    sb_if.i_busy_negedge_detected = 1'b1; step();
    sb_if.i_busy_negedge_detected = 1'b0;
    chk_out("finished2", 4'h0, 0, 0, 1, 0);
    sb_if.i_en = 1'b0; step();
    chk_out("disable", 4'h0, 0, 0, 0, 0);
    chk("disable.lanes_held", sb_if.o_lanes_result, 16'hA5A5);

    // end_req with no pt_done
    sb_if.i_en = 1'b1; step();
    sbmsg(1'b1, 4'b0001); step();
    sbmsg(1'b0, 4'h0); step();
    chk("entry_clear", sb_if.o_lanes_result, 16'h0000);
    sbmsg(1'b1, 4'b0011); step();
    sbmsg(1'b0, 4'h0); step();
    chk("no_pt.ack", {15'h0, sb_if.o_test_ack}, 16'h1);
    chk("no_pt.lanes", sb_if.o_lanes_result, 16'h0000);

    // Last pulse wins; pulse coinciding with end_req is captured
    sb_if.i_en = 1'b0; step();
    sb_if.i_en = 1'b1; step();
    sbmsg(1'b1, 4'b0001); step();
    sbmsg(1'b0, 4'h0); step();
    ptdone(1'b1, 16'hFFFF); step();
    ptdone(1'b1, 16'h00F0); step();
    chk("last_wins", sb_if.o_lanes_result, 16'h00F0);
    ptdone(1'b1, 16'h1234); sbmsg(1'b1, 4'b0011); step();
    ptdone(1'b0, 16'h0); sbmsg(1'b0, 4'h0);
    chk("coincident", sb_if.o_lanes_result, 16'h1234);
    chk("coincident.msg", {12'h0, sb_if.o_sideband_message}, 16'h0004);
    step();
    chk("coincident.ack", {15'h0, sb_if.o_test_ack}, 16'h1);
    chk("coincident.lanes", sb_if.o_lanes_result, 16'h1234);

    // i_en drop in RX_TEST
    sb_if.i_en = 1'b0; step();
    sb_if.i_en = 1'b1; step();
    sbmsg(1'b1, 4'b0001); step();
    sbmsg(1'b0, 4'h0); step();
    chk("abort.pt_en", {15'h0, sb_if.o_rx_pt_en}, 16'h1);
    sb_if.i_en = 1'b0; step();
    chk_out("abort", 4'h0, 0, 0, 0, 0);

    // rst pulsed in END_RESP
    sb_if.i_en = 1'b1; step();
    sbmsg(1'b1, 4'b0001); step();
    sbmsg(1'b0, 4'h0); step();
    ptdone(1'b1, 16'h5A5A); step();
    ptdone(1'b0, 16'h0);
    sbmsg(1'b1, 4'b0011); step();
    sbmsg(1'b0, 4'h0);
    chk("pre_rst.msg", {12'h0, sb_if.o_sideband_message}, 16'h0004);
    rst = 1'b1; #2;
    chk_out("async_rst", 4'h0, 0, 0, 0, 0);
    chk("async_rst.lanes", sb_if.o_lanes_result, 16'h0000);
    step();
    rst = 1'b0; step();                         // IDLE -> WAIT_START_REQ
    chk_out("post_rst", 4'h0, 0, 0, 0, 0);
    sbmsg(1'b1, 4'b0001); step();
    sbmsg(1'b0, 4'h0);
    chk_out("restart", 4'b0010, 1, 0, 0, 0);

    // Wait-state timeout
    sb_if.i_en = 1'b0; step();
    sb_if.i_en = 1'b1; step();                  // WAIT_START_REQ entered
    for (int i = 0; i < 15; i++) step();
    chk_out("pre_timeout", 4'h0, 0, 0, 0, 0);
    step();
`ifdef TRAIN_CENTER_CAL_RX_TIMEOUT_EN
    chk_out("timeout", 4'h0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step();
    chk_out("timeout_sticky", 4'h0, 0, 0, 1, 1);
    sb_if.i_en = 1'b0; step();
    chk_out("timeout_clear", 4'h0, 0, 0, 0, 0);
`else
    chk_out("no_timeout", 4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step();
    chk_out("still_waiting", 4'h0, 0, 0, 0, 0);
    sbmsg(1'b1, 4'b0001); step();
    sbmsg(1'b0, 4'h0);
    chk_out("late_start", 4'b0010, 1, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
